pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 123 ++++++++++++
 tb/tb_pc_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter register with branch/jump source select, trap entry on external exception or misaligned target, and eret.
// Single-cycle update; stall holds pc/epc/cause/FSM but never blocks trap entry.
module pc_sequencer #(
  parameter int                WIDTH        = 32,
  parameter int                NSRC         = 4,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(32'h0000_0180)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NSRC*WIDTH-1:0]    src_data,
  input  logic [$clog2(NSRC)-1:0]  PCsource,
  input  logic                     PCwrite,
  input  logic                     PCwriteCOND,
  input  logic                     cond_invert,
  input  logic                     zeroSignal,
  input  logic                     stall,
  input  logic                     exception,
  input  logic                     eret,
  output logic [WIDTH-1:0]         pc,
  output logic [WIDTH-1:0]         epc,
  output logic [1:0]               cause,
  output logic                     in_trap,
  output logic                     double_fault,
  output logic                     pc_written
);

  localparam int SW = $clog2(NSRC);
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_MIS  = 2'b10;

  typedef enum logic {RUN, TRAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [1:0]       cause_q, cause_d;
  logic             double_fault_q, double_fault_d;
  logic             pc_written_q, pc_written_d;

  logic [WIDTH-1:0] target;
  logic             src_ok;
  logic             take;
  logic             take_eff;
  logic             misaligned;
  logic             trap_req;

  // Selects outside 0..NSRC-1 (non-power-of-two NSRC) leave src_ok low and kill the take.
  always_comb begin
    target = '0;
    src_ok = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (PCsource == SW'(i)) begin
        target = src_data[i*WIDTH +: WIDTH];
        src_ok = 1'b1;
      end
    end
  end

  assign take       = PCwrite | (PCwriteCOND & (zeroSignal ^ cond_invert));
  assign take_eff   = take & src_ok;
  assign misaligned = take_eff & (target[1:0] != 2'b00);
  assign trap_req   = exception | misaligned;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    epc_d          = epc_q;
    cause_d        = cause_q;
    double_fault_d = double_fault_q;
    pc_written_d   = 1'b0;
    if (state_q == RUN && trap_req) begin
      state_d      = TRAP;
      pc_d         = EXC_VECTOR;
      epc_d        = pc_q;
      cause_d      = exception ? CAUSE_EXT : CAUSE_MIS;
      pc_written_d = 1'b1;
    end else begin
      // A trap request while already trapped is recorded but never nests.
      if (state_q == TRAP && trap_req) begin
        double_fault_d = 1'b1;
      end
      if (!stall) begin
        if (state_q == TRAP && eret) begin
          state_d      = RUN;
          pc_d         = epc_q;
          cause_d      = CAUSE_NONE;
          pc_written_d = 1'b1;
        end else if (take_eff && !misaligned) begin
          pc_d         = target;
          pc_written_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= RUN;
      pc_q           <= RESET_VECTOR;
      epc_q          <= '0;
      cause_q        <= CAUSE_NONE;
      double_fault_q <= 1'b0;
      pc_written_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      epc_q          <= epc_d;
      cause_q        <= cause_d;
      double_fault_q <= double_fault_d;
      pc_written_q   <= pc_written_d;
    end
  end

  assign pc           = pc_q;
  assign epc          = epc_q;
  assign cause        = cause_q;
  assign in_trap      = (state_q == TRAP);
  assign double_fault = double_fault_q;
  assign pc_written   = pc_written_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer: per-cycle vectors with expected post-edge state, queued and checked after each edge.
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (WIDTH=32, NSRC=4)
  logic         rst, pcw, pcc, inv, zero, stl, exc, ert;
  logic [1:0]   sel;
  logic [127:0] src;
  logic [31:0]  pc_o, epc_o;
  logic [1:0]   cause_o;
  logic         trap_o, df_o, wr_o;

  pc_sequencer dut (
    .Clk(clk), .Reset(rst), .src_data(src), .PCsource(sel),
    .PCwrite(pcw), .PCwriteCOND(pcc), .cond_invert(inv), .zeroSignal(zero),
    .stall(stl), .exception(exc), .eret(ert),
    .pc(pc_o), .epc(epc_o), .cause(cause_o), .in_trap(trap_o),
    .double_fault(df_o), .pc_written(wr_o)
  );

  // NSRC=3 instance: select value 3 has no source behind it
  logic         rst3, pcw3;
  logic [1:0]   sel3;
  logic [95:0]  src3;
  logic [31:0]  pc3, epc3;
  logic [1:0]   cause3;
  logic         trap3, df3, wr3;

  pc_sequencer #(.NSRC(3)) dut3 (
    .Clk(clk), .Reset(rst3), .src_data(src3), .PCsource(sel3),
    .PCwrite(pcw3), .PCwriteCOND(1'b0), .cond_invert(1'b0), .zeroSignal(1'b0),
    .stall(1'b0), .exception(1'b0), .eret(1'b0),
    .pc(pc3), .epc(epc3), .cause(cause3), .in_trap(trap3),
    .double_fault(df3), .pc_written(wr3)
  );

  typedef struct {
    logic        rst, pcw, pcc, inv, zero;
    logic [1:0]  sel;
    logic [31:0] tgt;
    logic        stall, exc, eret;
    logic [31:0] e_pc, e_epc;
    logic [1:0]  e_cause;
    logic        e_trap, e_df, e_wr;
  } vec_t;

  typedef struct {
    int          row;
    logic [31:0] pc, epc;
    logic [1:0]  cause;
    logic        trap, df, wr;
  } exp_t;

  localparam int NV = 21;
  vec_t vecs [NV];
  exp_t sb [$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", nm, row, act, exp);
    end
  endtask

  task automatic check_main();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    chk("pc",           e.row, pc_o,           e.pc);
    chk("epc",          e.row, epc_o,          e.epc);
    chk("cause",        e.row, 32'(cause_o),   32'(e.cause));
    chk("in_trap",      e.row, 32'(trap_o),    32'(e.trap));
    chk("double_fault", e.row, 32'(df_o),      32'(e.df));
    chk("pc_written",   e.row, 32'(wr_o),      32'(e.wr));
  endtask

  initial begin
    //           rst pcw pcc inv zr sel  tgt          stl exc ert  e_pc          e_epc         cs    tr df wr
    vecs[0]  = '{1, 0, 0, 0, 0, 2'd0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 2'd0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 2'd0, 32'h0000_0004, 0, 0, 0, 32'h0000_0004, 32'h0000_0000, 2'd0, 0, 0, 1};
    vecs[2]  = '{0, 0, 0, 0, 0, 2'd0, 32'h0000_0008, 0, 0, 0, 32'h0000_0004, 32'h0000_0000, 2'd0, 0, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 0, 2'd2, 32'h0000_0040, 0, 0, 0, 32'h0000_0040, 32'h0000_0000, 2'd0, 0, 0, 1};
    vecs[4]  = '{0, 0, 1, 0, 0, 2'd1, 32'h0000_0100, 0, 0, 0, 32'h0000_0040, 32'h0000_0000, 2'd0, 0, 0, 0};
    vecs[5]  = '{0, 0, 1, 1, 0, 2'd1, 32'h0000_0100, 0, 0, 0, 32'h0000_0100, 32'h0000_0000, 2'd0, 0, 0, 1};
    vecs[6]  = '{0, 0, 1, 0, 1, 2'd3, 32'h0000_0020, 0, 0, 0, 32'h0000_0020, 32'h0000_0000, 2'd0, 0, 0, 1};
    vecs[7]  = '{0, 0, 1, 1, 1, 2'd0, 32'h0000_0008, 0, 0, 0, 32'h0000_0020, 32'h0000_0000, 2'd0, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 0, 0, 2'd1, 32'h0000_0102, 0, 0, 0, 32'h0000_0180, 32'h0000_0020, 2'd2, 1, 0, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 2'd0, 32'h0000_0008, 0, 0, 1, 32'h0000_0020, 32'h0000_0020, 2'd0, 0, 0, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 2'd0, 32'h0000_0008, 0, 0, 1, 32'h0000_0020, 32'h0000_0020, 2'd0, 0, 0, 0};
    vecs[11] = '{0, 1, 0, 0, 0, 2'd0, 32'h0000_0060, 0, 0, 0, 32'h0000_0060, 32'h0000_0020, 2'd0, 0, 0, 1};
    vecs[12] = '{0, 1, 0, 0, 0, 2'd0, 32'h0000_0070, 1, 0, 0, 32'h0000_0060, 32'h0000_0020, 2'd0, 0, 0, 0};
    vecs[13] = '{0, 0, 0, 0, 0, 2'd0, 32'h0000_0008, 1, 1, 0, 32'h0000_0180, 32'h0000_0060, 2'd1, 1, 0, 1};
    vecs[14] = '{0, 0, 0, 0, 0, 2'd0, 32'h0000_0008, 1, 0, 1, 32'h0000_0180, 32'h0000_0060, 2'd1, 1, 0, 0};
    vecs[15] = '{0, 1, 0, 0, 0, 2'd2, 32'h0000_0200, 0, 0, 0, 32'h0000_0200, 32'h0000_0060, 2'd1, 1, 0, 1};
    vecs[16] = '{0, 0, 0, 0, 0, 2'd0, 32'h0000_0008, 0, 1, 0, 32'h0000_0200, 32'h0000_0060, 2'd1, 1, 1, 0};
    vecs[17] = '{0, 0, 0, 0, 0, 2'd0, 32'h0000_0008, 0, 0, 1, 32'h0000_0060, 32'h0000_0060, 2'd0, 0, 1, 1};
    vecs[18] = '{0, 1, 0, 0, 0, 2'd0, 32'h0000_0003, 0, 1, 0, 32'h0000_0180, 32'h0000_0060, 2'd1, 1, 1, 1};
    vecs[19] = '{1, 0, 0, 0, 0, 2'd0, 32'h0000_0008, 0, 1, 0, 32'h0000_0000, 32'h0000_0000, 2'd0, 0, 0, 0};
    vecs[20] = '{0, 1, 0, 0, 0, 2'd0, 32'h0000_0004, 0, 0, 0, 32'h0000_0004, 32'h0000_0000, 2'd0, 0, 0, 1};

    rst = 1'b1; pcw = 0; pcc = 0; inv = 0; zero = 0; stl = 0; exc = 0; ert = 0;
    sel = '0; src = '0;
    rst3 = 1'b1; pcw3 = 0; sel3 = '0; src3 = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010};

    for (int r = 0; r < NV; r++) begin
      exp_t e;
      @(negedge clk);
      rst  = vecs[r].rst;  pcw = vecs[r].pcw;  pcc = vecs[r].pcc;
      inv  = vecs[r].inv;  zero = vecs[r].zero; sel = vecs[r].sel;
      stl  = vecs[r].stall; exc = vecs[r].exc; ert = vecs[r].eret;
      // Unselected slots carry a misaligned value so a wrong mux pick shows up as a trap
      for (int s = 0; s < 4; s++)
        src[s*32 +: 32] = (s == int'(vecs[r].sel)) ? vecs[r].tgt : 32'h0000_0003;
      e.row = r; e.pc = vecs[r].e_pc; e.epc = vecs[r].e_epc; e.cause = vecs[r].e_cause;
      e.trap = vecs[r].e_trap; e.df = vecs[r].e_df; e.wr = vecs[r].e_wr;
      sb.push_back(e);
      @(posedge clk); #1;
      check_main();
    end

    // pc_written must fall again after a single cycle once inputs go idle
    @(negedge clk);
    pcw = 0;
    @(posedge clk); #1;
    chk("pc_written_drop", NV, 32'(wr_o), 32'd0);
    chk("pc_hold_idle",    NV, pc_o,      32'h0000_0004);

    // NSRC=3: reset, valid load via source 1, then out-of-range select is a no-op
    @(negedge clk); rst3 = 1'b1;
    @(posedge clk); #1;
    chk("n3_reset_pc", 100, pc3, 32'h0000_0000);
    @(negedge clk); rst3 = 1'b0; pcw3 = 1'b1; sel3 = 2'd1;
    @(posedge clk); #1;
    chk("n3_load_pc", 101, pc3, 32'h0000_0020);
    chk("n3_load_wr", 101, 32'(wr3), 32'd1);
    @(negedge clk); sel3 = 2'd3;
    @(posedge clk); #1;
    chk("n3_bad_sel_pc",    102, pc3, 32'h0000_0020);
    chk("n3_bad_sel_wr",    102, 32'(wr3), 32'd0);
    chk("n3_bad_sel_cause", 102, 32'(cause3), 32'd0);
    chk("n3_bad_sel_trap",  102, 32'(trap3), 32'd0);
    @(negedge clk); pcw3 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
